// File: rtl/l1b_pkg.sv
`default_nettype none
// ============================================================================
// l1b_pkg : shared L1B bank defaults and weight-read sequencer state encoding
// Revision: 1.0
// ============================================================================
package l1b_pkg;

    localparam int L1B_RAM_DEPTH_DEF = 256;
    localparam int BANK_CH_DEF       = 16;
    localparam int CREDITS_DEF       = 4;

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_ISSUE = 2'd1,
        SEQ_DRAIN = 2'd2,
        SEQ_DONE  = 2'd3
    } l1b_seq_state_e;

endpackage
`default_nettype wire

// File: rtl/l1b_credit_cnt.sv
`default_nettype none
// ============================================================================
// l1b_credit_cnt : consumer-slot credit counter with saturation and sticky error
// Revision: 1.0
// ============================================================================
module l1b_credit_cnt #(
    parameter int CREDITS = 4,
    localparam int CRD_W  = $clog2(CREDITS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [CRD_W-1:0] count,
    output logic             err
);

    localparam logic [CRD_W-1:0] FULL = CRD_W'(CREDITS);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= FULL;
            err   <= 1'b0;
        end else if (inc && !dec) begin
            // A return with no slot outstanding is a consumer bug: saturate and flag it.
            if (count == FULL) begin
                err <= 1'b1;
            end else begin
                count <= count + 1'b1;
            end
        end else if (dec && !inc) begin
            count <= count - 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/l1b_weight_rd_seq.sv
`default_nettype none
// ============================================================================
// l1b_weight_rd_seq : strided weight-row read sequencer for one L1B bank
// Revision: 1.0
// ============================================================================
module l1b_weight_rd_seq
    import l1b_pkg::*;
#(
    parameter int BANK_CH       = BANK_CH_DEF,
    parameter int L1B_RAM_DEPTH = L1B_RAM_DEPTH_DEF,
    parameter int CREDITS       = CREDITS_DEF,
    localparam int ADDR_W       = $clog2(L1B_RAM_DEPTH),
    localparam int LEN_W        = ADDR_W + 1,
    localparam int CRD_W        = $clog2(CREDITS + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [ADDR_W-1:0]  cmd_base_addr,
    input  logic [ADDR_W-1:0]  cmd_stride,
    input  logic [LEN_W-1:0]   cmd_len,
    input  logic [BANK_CH-1:0] cmd_ch_mask,
    input  logic [1:0]         cmd_dst_sel,
    input  logic               abort,
    input  logic               l1b_gpu_mode,
    input  logic               tcache_data_busy,
    input  logic               credit_return,
    output logic [BANK_CH-1:0] tcache_data_cs,
    output logic               tcache_data_data_we,
    output logic [ADDR_W-1:0]  tcache_data_addr,
    output logic               l1b_weight_rd_mode,
    output logic [1:0]         l1b_mv_cub_dst_sel,
    output logic               seq_busy,
    output logic               seq_done,
    output logic               seq_aborted,
    output logic               credit_err
);

    localparam logic [ADDR_W:0] DEPTH = (ADDR_W + 1)'(L1B_RAM_DEPTH);

    l1b_seq_state_e     state;
    logic [ADDR_W-1:0]  row;
    logic [ADDR_W-1:0]  stride_r;
    logic [LEN_W-1:0]   remaining;
    logic [BANK_CH-1:0] mask_r;
    logic [1:0]         dst_r;
    logic               aborted_r;

    logic [CRD_W-1:0]   credit;
    logic               issue;
    logic               rd_window;
    logic [ADDR_W:0]    row_sum;
    logic [ADDR_W-1:0]  row_next;

    assign issue = (state == SEQ_ISSUE) && !l1b_gpu_mode && !tcache_data_busy
                   && (credit != '0) && !abort;

    // Both operands are below DEPTH, so one conditional subtract gives the modulo.
    assign row_sum  = {1'b0, row} + {1'b0, stride_r};
    assign row_next = (row_sum >= DEPTH) ? ADDR_W'(row_sum - DEPTH) : row_sum[ADDR_W-1:0];

    l1b_credit_cnt #(
        .CREDITS (CREDITS)
    ) u_credit (
        .clk   (clk),
        .rst   (rst),
        .inc   (credit_return),
        .dec   (issue),
        .count (credit),
        .err   (credit_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SEQ_IDLE;
            row       <= '0;
            stride_r  <= '0;
            remaining <= '0;
            mask_r    <= '0;
            dst_r     <= '0;
            aborted_r <= 1'b0;
        end else begin
            case (state)
                SEQ_IDLE: begin
                    if (cmd_valid) begin
                        row       <= cmd_base_addr;
                        stride_r  <= cmd_stride;
                        remaining <= cmd_len;
                        mask_r    <= cmd_ch_mask;
                        dst_r     <= cmd_dst_sel;
                        aborted_r <= 1'b0;
                        state     <= (cmd_len == '0) ? SEQ_DONE : SEQ_ISSUE;
                    end
                end
                SEQ_ISSUE: begin
                    if (abort) begin
                        aborted_r <= 1'b1;
                        state     <= SEQ_DRAIN;
                    end else if (issue) begin
                        row       <= row_next;
                        remaining <= remaining - 1'b1;
                        if (remaining == LEN_W'(1)) begin
                            state <= SEQ_DRAIN;
                        end
                    end
                end
                SEQ_DRAIN: state <= SEQ_DONE;
                default:   state <= SEQ_IDLE;
            endcase
        end
    end

    // DRAIN keeps the weight path selected while the last row's read data returns.
    assign rd_window           = (state == SEQ_ISSUE) || (state == SEQ_DRAIN);
    assign cmd_ready           = (state == SEQ_IDLE);
    assign tcache_data_cs      = issue ? mask_r : '0;
    assign tcache_data_addr    = row;
    assign tcache_data_data_we = 1'b0;
    assign l1b_weight_rd_mode  = rd_window;
    assign l1b_mv_cub_dst_sel  = rd_window ? dst_r : 2'b00;
    assign seq_busy            = (state != SEQ_IDLE);
    assign seq_done            = (state == SEQ_DONE);
    assign seq_aborted         = (state == SEQ_DONE) && aborted_r;

endmodule
`default_nettype wire

// File: tb/tb_l1b_weight_rd_seq.sv
`default_nettype none
// ============================================================================
// tb_l1b_weight_rd_seq : directed plus randomized bench for l1b_weight_rd_seq
// Revision: 1.0
// ============================================================================
module tb_l1b_weight_rd_seq;

    localparam int DEPTH = 256;
    localparam int NCRED = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_base_addr;
    logic [7:0]  cmd_stride;
    logic [8:0]  cmd_len;
    logic [15:0] cmd_ch_mask;
    logic [1:0]  cmd_dst_sel;
    logic        abort;
    logic        l1b_gpu_mode;
    logic        tcache_data_busy;
    logic        credit_return;
    logic [15:0] tcache_data_cs;
    logic        tcache_data_data_we;
    logic [7:0]  tcache_data_addr;
    logic        l1b_weight_rd_mode;
    logic [1:0]  l1b_mv_cub_dst_sel;
    logic        seq_busy;
    logic        seq_done;
    logic        seq_aborted;
    logic        credit_err;

    always #5 clk = ~clk;

    l1b_weight_rd_seq dut (
        .clk                 (clk),
        .rst                 (rst),
        .cmd_valid           (cmd_valid),
        .cmd_ready           (cmd_ready),
        .cmd_base_addr       (cmd_base_addr),
        .cmd_stride          (cmd_stride),
        .cmd_len             (cmd_len),
        .cmd_ch_mask         (cmd_ch_mask),
        .cmd_dst_sel         (cmd_dst_sel),
        .abort               (abort),
        .l1b_gpu_mode        (l1b_gpu_mode),
        .tcache_data_busy    (tcache_data_busy),
        .credit_return       (credit_return),
        .tcache_data_cs      (tcache_data_cs),
        .tcache_data_data_we (tcache_data_data_we),
        .tcache_data_addr    (tcache_data_addr),
        .l1b_weight_rd_mode  (l1b_weight_rd_mode),
        .l1b_mv_cub_dst_sel  (l1b_mv_cub_dst_sel),
        .seq_busy            (seq_busy),
        .seq_done            (seq_done),
        .seq_aborted         (seq_aborted),
        .credit_err          (credit_err)
    );

    int vectors    = 0;
    int miscompares = 0;
    int cyc        = 0;
    bit armed      = 1'b0;

    // Behavioural model: a command is a list of row addresses to emit, then a fixed tail.
    int          m_phase  = 0;   // 0 idle, 1 emitting rows, 2 drain, 3 done
    int          m_rows[$];
    int          m_credit = NCRED;
    bit          m_err    = 1'b0;
    bit          m_ab     = 1'b0;
    logic [15:0] m_mask   = '0;
    logic [1:0]  m_dst    = '0;

    int seen[$];
    int done_cyc;
    bit done_seen;
    bit done_ab;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    task automatic compare_and_advance();
        bit iss;
        bit win;
        iss = (m_phase == 1) && !l1b_gpu_mode && !tcache_data_busy && (m_credit > 0) && !abort;
        win = (m_phase == 1) || (m_phase == 2);
        if (armed) begin
            chk("cmd_ready", 32'(cmd_ready), 32'(m_phase == 0));
            chk("cs", 32'(tcache_data_cs), iss ? 32'(m_mask) : 32'd0);
            if (iss) chk("addr", 32'(tcache_data_addr), 32'(m_rows[0]));
            chk("data_we", 32'(tcache_data_data_we), 32'd0);
            chk("rd_mode", 32'(l1b_weight_rd_mode), 32'(win));
            chk("dst_sel", 32'(l1b_mv_cub_dst_sel), win ? 32'(m_dst) : 32'd0);
            chk("seq_busy", 32'(seq_busy), 32'(m_phase != 0));
            chk("seq_done", 32'(seq_done), 32'(m_phase == 3));
            chk("seq_aborted", 32'(seq_aborted), 32'((m_phase == 3) && m_ab));
            chk("credit_err", 32'(credit_err), 32'(m_err));
        end
        if (tcache_data_cs != 16'd0) seen.push_back(int'(tcache_data_addr));
        if (seq_done === 1'b1) begin
            done_seen = 1'b1;
            done_cyc  = cyc;
            done_ab   = seq_aborted;
        end
        if (rst) begin
            m_phase = 0; m_rows.delete(); m_credit = NCRED; m_err = 1'b0; m_ab = 1'b0;
            m_mask = '0; m_dst = '0; armed = 1'b1;
        end else begin
            if (credit_return && !iss && m_credit == NCRED) m_err = 1'b1;
            else m_credit = m_credit + int'(credit_return) - int'(iss);
            case (m_phase)
                0: if (cmd_valid) begin
                    m_mask = cmd_ch_mask;
                    m_dst  = cmd_dst_sel;
                    m_ab   = 1'b0;
                    for (int i = 0; i < int'(cmd_len); i++)
                        m_rows.push_back((int'(cmd_base_addr) + i * int'(cmd_stride)) % DEPTH);
                    m_phase = (cmd_len == 0) ? 3 : 1;
                end
                1: if (abort) begin
                    m_ab = 1'b1; m_rows.delete(); m_phase = 2;
                end else if (iss) begin
                    void'(m_rows.pop_front());
                    if (m_rows.size() == 0) m_phase = 2;
                end
                2: m_phase = 3;
                default: m_phase = 0;
            endcase
        end
        cyc++;
    endtask

    task automatic step();
        @(negedge clk);
        compare_and_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cmd_valid = 0; abort = 0; l1b_gpu_mode = 0; tcache_data_busy = 0; credit_return = 0; rst = 0;
    endtask

    task automatic send(input int base, input int stride, input int len, input logic [15:0] mask,
                        input logic [1:0] dst, output int t_acc);
        cmd_valid = 1; cmd_base_addr = 8'(base); cmd_stride = 8'(stride); cmd_len = 9'(len);
        cmd_ch_mask = mask; cmd_dst_sel = dst;
        seen.delete(); done_seen = 1'b0;
        t_acc = cyc;
        step();
        cmd_valid = 0;
    endtask

    task automatic run_until_done(input string nm, input int budget);
        int n = 0;
        while (!done_seen && n < budget) begin step(); n++; end
        if (!done_seen) chk({nm, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic return_credits(input int n);
        for (int i = 0; i < n; i++) begin credit_return = 1; step(); end
        credit_return = 0;
    endtask

    task automatic chk_seen(input string nm, input int n, input int a0, input int a1, input int a2, input int a3);
        int e[4];
        e = '{a0, a1, a2, a3};
        chk({nm, "_count"}, 32'(seen.size()), 32'(n));
        for (int i = 0; i < n && i < seen.size(); i++) chk({nm, "_row"}, 32'(seen[i]), 32'(e[i]));
    endtask

    initial begin
        int t;
        cmd_base_addr = 0; cmd_stride = 0; cmd_len = 0; cmd_ch_mask = 0; cmd_dst_sel = 0;
        idle_inputs();
        rst = 1;
        step(); step();
        rst = 0;
        step();
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_cs", 32'(tcache_data_cs), 32'd0);
        chk("rst_addr", 32'(tcache_data_addr), 32'd0);
        chk("rst_busy", 32'(seq_busy), 32'd0);
        chk("rst_err", 32'(credit_err), 32'd0);

        // 1: simple increment
        send(10, 1, 4, 16'hFFFF, 2'd1, t);
        run_until_done("t1", 50);
        chk_seen("t1", 4, 10, 11, 12, 13);
        chk("t1_done_lat", 32'(done_cyc - t), 32'd6);
        return_credits(4);

        // 2: wrap past the top of the bank
        send(250, 3, 3, 16'h00F0, 2'd2, t);
        run_until_done("t2", 50);
        chk_seen("t2", 3, 250, 253, 0, 0);
        chk("t2_done_lat", 32'(done_cyc - t), 32'd5);
        return_credits(3);

        // 3: credit starvation
        send(0, 1, 6, 16'hA5A5, 2'd3, t);
        for (int i = 0; i < 10; i++) step();
        chk("t3_stalled", 32'(seen.size()), 32'd4);
        return_credits(2);
        run_until_done("t3", 50);
        chk("t3_total", 32'(seen.size()), 32'd6);
        if (seen.size() == 6) chk("t3_row5", 32'(seen[5]), 32'd5);
        chk("t3_model_credit", 32'(m_credit), 32'd0);
        return_credits(4);

        // 4: LSU busy and GPU mode yield
        send(20, 2, 4, 16'h0001, 2'd0, t);
        step();
        tcache_data_busy = 1; step(); tcache_data_busy = 0;
        step();
        l1b_gpu_mode = 1; step(); step(); step(); l1b_gpu_mode = 0;
        run_until_done("t4", 50);
        chk_seen("t4", 4, 20, 22, 24, 26);
        chk("t4_done_lat", 32'(done_cyc - t), 32'd10);
        return_credits(4);

        // 5: abort on the third row
        send(100, 5, 8, 16'hFFFF, 2'd1, t);
        step(); step();
        abort = 1; step(); abort = 0;
        run_until_done("t5", 50);
        chk_seen("t5", 2, 100, 105, 0, 0);
        chk("t5_done_lat", 32'(done_cyc - t), 32'd5);
        chk("t5_aborted", 32'(done_ab), 32'd1);
        send(7, 1, 0, 16'hFFFF, 2'd1, t);
        run_until_done("t5b", 10);
        chk("t5b_done_lat", 32'(done_cyc - t), 32'd1);
        chk("t5b_aborted", 32'(done_ab), 32'd0);
        return_credits(2);

        // 6: overflow return, then reset mid-command
        credit_return = 1; step(); credit_return = 0;
        step();
        chk("t6_err_set", 32'(credit_err), 32'd1);
        send(30, 1, 3, 16'hFFFF, 2'd2, t);
        step();
        chk("t6_err_sticky", 32'(credit_err), 32'd1);
        rst = 1; step(); rst = 0;
        step();
        chk("t6_rst_ready", 32'(cmd_ready), 32'd1);
        chk("t6_rst_err", 32'(credit_err), 32'd0);
        chk("t6_rst_rd_mode", 32'(l1b_weight_rd_mode), 32'd0);
        chk("t6_rst_addr", 32'(tcache_data_addr), 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            cmd_valid        = ($urandom_range(0, 3) == 0);
            cmd_base_addr    = 8'($urandom);
            cmd_stride       = 8'($urandom);
            cmd_len          = ($urandom_range(0, 40) == 0) ? 9'(DEPTH) : 9'($urandom_range(0, 12));
            cmd_ch_mask      = 16'($urandom);
            cmd_dst_sel      = 2'($urandom);
            abort            = ($urandom_range(0, 29) == 0);
            l1b_gpu_mode     = ($urandom_range(0, 7) == 0);
            tcache_data_busy = ($urandom_range(0, 5) == 0);
            credit_return    = ($urandom_range(0, 2) == 0);
            rst              = ($urandom_range(0, 499) == 0);
            step();
        end
        idle_inputs();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
